pc_call_stack: RTL and testbench
================================

Name: pc_call_stack

Overview:
- Parametrised program counter for the CPU fetch path: hold, increment, load, call and return.
- Integrated return-address stack (LIFO) sits between the instruction decoder's control strobes and the instruction-memory address bus.
- Adds call/return, depth status and sticky error flags.

Parameters:
- WIDTH, 16, bit width of the PC, `in` and each stack entry.
- DEPTH, 8, number of return-address entries; must be ≥2.
- TRAP_VEC, 0, PC value loaded on stack error when PC_TRAP_EN is defined; truncated to WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- in  input  WIDTH  jump/call target.
- inc  input  1  PC ← PC+1.
- load  input  1  PC ← in (jump).
- call  input  1  push PC+1, then PC ← in.
- ret  input  1  PC ← top of stack, pop.
- out  output  WIDTH  current PC (registered).
- level  output  $clog2(DEPTH+1)  number of valid stack entries.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- overflow  output  1  sticky: a call was made while full.
- underflow  output  1  sticky: a ret was made while empty.

Behaviour:
- Reset (reset==0 at a rising edge):
  - out=0, level=0, overflow=0, underflow=0.
  - Stack contents are don't-care.
  - Reset overrides every other strobe. Reset mid-call/ret discards that operation.
- Priority when several strobes are high: load > call > ret > inc > hold. Exactly one operation executes per cycle.
- Latency:
  - Every operation takes effect at the edge where it is sampled; `out` shows the new value the same edge.
  - Status outputs (level/full/empty/flags) are combinational from registered state.
- Hold: out, stack and flags unchanged.
- inc: out ← out+1 modulo 2^WIDTH. All-ones wraps to 0; no flag raised.
- load: out ← in. Stack untouched.
- call, not full:
  - stack[level] ← out+1 (mod 2^WIDTH); level ← level+1; out ← in.
- call, full:
  - out ← in; push discarded; level stays DEPTH; overflow ← 1.
- ret, not empty:
  - out ← stack[level-1]; level ← level-1.
- ret, empty:
  - out holds; underflow ← 1.
- Call then immediate ret (consecutive cycles) returns to caller+1.
- Stack never wraps: the oldest entry is never overwritten.
- overflow and underflow clear only on reset.
- The next-PC select is a single registered mux state machine. Op-states are HOLD, INC, LOAD, CALL, RET, RESET, decoded each cycle from the strobes.

Optional Feature:
- Macro: PC_TRAP_EN.
- Defined:
  - A call while full, or a ret while empty, sets the corresponding flag and forces out ← TRAP_VEC at that edge.
  - This overrides `in` for the call, and overrides the hold for the ret.
  - Stack and level are unchanged.
- Undefined: behaviour exactly as above; TRAP_VEC is unused.

Decomposition:
- Shared package pc_pkg holds:
  - pc_op_t enum: OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET, OP_RESET.
  - Function pc_decode(reset, load, call, ret, inc) returning pc_op_t by the priority above.
  - Width helper for `level`.
- One sub-module: ras_lifo (WIDTH, DEPTH).
  - Ports: push, pop, wdata, rdata (top), level, full, empty.
  - Protects itself: ignores push when full and pop when empty.
  - pc_call_stack owns the PC register and the flags.

Test Plan:
- reset=0 for one edge with load=1, in=16'h1234 → out=0, level=0, empty=1, both flags 0.
- out=16'hFFFE, inc for 2 cycles → out=16'hFFFF, then 16'h0000; no flags.
- out=16'h0010, call in=16'h0200 → out=16'h0200, level=1. Then inc, ret → out=16'h0011, level=0, empty=1.
- Nested calls from out=16'h0000 with DEPTH=8:
  - 8 calls to 16'h0100..16'h0107 → full=1.
  - A 9th call to 16'h0300 → out=16'h0300, overflow=1, level=8.
  - 8 rets unwind in LIFO order.
- ret while empty at out=16'h0042 → out stays 16'h0042, underflow=1. Later a valid call does not clear it; only reset does.
- Simultaneous strobes:
  - load+call+ret+inc, in=16'h0AAA → out=16'h0AAA, level unchanged.
  - call+ret → push occurs.
- With PC_TRAP_EN and TRAP_VEC=16'h0008, ret while empty → out=16'h0008, underflow=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter with return-address stack.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pc_pkg;

  // One operation executes per cycle; RESET is decoded like any other op.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_RESET
  } pc_op_t;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int pc_level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Strobe priority: reset > load > call > ret > inc > hold.
  function automatic pc_op_t pc_decode(input logic reset, input logic load,
                                       input logic call, input logic ret,
                                       input logic inc);
    pc_op_t op;
    if (!reset)     op = OP_RESET;
    else if (load)  op = OP_LOAD;
    else if (call)  op = OP_CALL;
    else if (ret)   op = OP_RET;
    else if (inc)   op = OP_INC;
    else            op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/ras_lifo.sv
// Return-address LIFO: push/pop of WIDTH-bit entries, never wraps or overwrites.
// Latency: push/pop take effect at the sampling edge; rdata/level/full/empty come from registers.
// Backpressure: none; push while full and pop while empty are silently ignored.
module ras_lifo
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [pc_level_w(DEPTH)-1:0] level,
  output logic                         full,
  output logic                         empty
);

  localparam int LW = pc_level_w(DEPTH);
  localparam int IW = $clog2(DEPTH);

  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  // Status and top-of-stack are pure functions of the registered level.
  always_comb begin
    full   = (level_q == LW'(DEPTH));
    empty  = (level_q == '0);
    level  = level_q;
    wr_idx = level_q[IW-1:0];
    rd_idx = IW'(level_q - LW'(1));
    rdata  = empty ? '0 : mem_q[rd_idx];
  end

  // Next level and storage; push wins if both strobes arrive together.
  always_comb begin
    mem_d   = mem_q;
    level_d = level_q;
    do_push = push && !full;
    do_pop  = pop && !push && !empty;
    if (do_push) begin
      mem_d[wr_idx] = wdata;
      level_d       = level_q + LW'(1);
    end else if (do_pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // Level register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) level_q <= '0;
    else        level_q <= level_d;
  end

  // Entry storage needs no reset: entries above level are never read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with hold/inc/load/call/ret and an integrated return-address stack.
// Latency: every op updates out at the sampling edge; status outputs are combinational from state.
// Backpressure: none; one op per cycle. Macro PC_TRAP_EN: stack errors force out to TRAP_VEC.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int TRAP_VEC = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in,
  input  logic                         inc,
  input  logic                         load,
  input  logic                         call,
  input  logic                         ret,
  output logic [WIDTH-1:0]             out,
  output logic [pc_level_w(DEPTH)-1:0] level,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
);

`ifdef PC_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VEC);

  pc_op_t           op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push, pop;
  logic [WIDTH-1:0] ras_top;

  ras_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (pc_q + WIDTH'(1)),
    .rdata (ras_top),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Decode the op for this cycle and select the next PC, flags and stack strobes.
  always_comb begin
    op    = pc_decode(reset, load, call, ret, inc);
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    case (op)
      OP_RESET: begin
        pc_d  = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      OP_INC:  pc_d = pc_q + WIDTH'(1);
      OP_LOAD: pc_d = in;
      OP_CALL: begin
        pc_d = in;
        if (full) begin
          ovf_d = 1'b1;
          if (TRAP_EN) pc_d = TRAP_PC;
        end else begin
          push = 1'b1;
        end
      end
      OP_RET: begin
        if (empty) begin
          unf_d = 1'b1;
          if (TRAP_EN) pc_d = TRAP_PC;
        end else begin
          pc_d = ras_top;
          pop  = 1'b1;
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  // PC and sticky error flags; the reset op already computes their cleared values.
  always_ff @(posedge clk) begin
    pc_q  <= pc_d;
    ovf_q <= ovf_d;
    unf_q <= unf_d;
  end

  assign out       = pc_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
module tb_pc_call_stack;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        inc, load, call, ret;
  logic [15:0] out;
  logic [3:0]  level;
  logic        full, empty, overflow, underflow;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef PC_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  pc_call_stack #(
    .WIDTH    (16),
    .DEPTH    (8),
    .TRAP_VEC (16'h0008)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .inc       (inc),
    .load      (load),
    .call      (call),
    .ret       (ret),
    .out       (out),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of strobes, then sample 1 time unit after the edge.
  task automatic cyc(input logic [15:0] i, input logic ld, input logic c,
                     input logic r, input logic n);
    in = i; load = ld; call = c; ret = r; inc = n;
    @(posedge clk);
    #1;
    load = 1'b0; call = 1'b0; ret = 1'b0; inc = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    n_cmp++; if (out !== 16'h0000) begin n_bad++; $display("FAIL reset_out: got %h want 0000", out); end
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL reset_empty_full: got %b%b want 10", empty, full); end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got %b%b want 00", overflow, underflow); end
  endtask

  task automatic test_inc_wrap();
    cyc(16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out !== 16'hFFFF) begin n_bad++; $display("FAIL inc_ffff: got %h want ffff", out); end
    cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out !== 16'h0000) begin n_bad++; $display("FAIL inc_wrap: got %h want 0000", out); end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_bad++; $display("FAIL inc_flags: got %b%b want 00", overflow, underflow); end
    cyc(16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out !== 16'h0000) begin n_bad++; $display("FAIL hold: got %h want 0000", out); end
  endtask

  task automatic test_call_ret();
    cyc(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(16'h0200, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out !== 16'h0200 || level !== 4'd1) begin n_bad++; $display("FAIL call: got out=%h lvl=%0d want 0200/1", out, level); end
    cyc(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out !== 16'h0201) begin n_bad++; $display("FAIL call_inc: got %h want 0201", out); end
    cyc(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (out !== 16'h0011 || level !== 4'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL ret: got out=%h lvl=%0d e=%b want 0011/0/1", out, level, empty); end
  endtask

  task automatic test_nested();
    logic [15:0] exp_stack [8];
    exp_stack[0] = 16'h0001;
    for (int k = 1; k < 8; k++) exp_stack[k] = 16'h0100 + 16'(k);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(16'h0100 + 16'(k), 1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (level !== 4'(k + 1)) begin n_bad++; $display("FAIL nest_level%0d: got %0d want %0d", k, level, k + 1); end
    end
    n_cmp++; if (full !== 1'b1 || out !== 16'h0107) begin n_bad++; $display("FAIL nest_full: got f=%b out=%h want 1/0107", full, out); end
    cyc(16'h0300, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out !== (TRAP ? 16'h0008 : 16'h0300)) begin n_bad++; $display("FAIL ovf_out: got %h want %h", out, TRAP ? 16'h0008 : 16'h0300); end
    n_cmp++; if (overflow !== 1'b1 || level !== 4'd8) begin n_bad++; $display("FAIL ovf_flag: got ovf=%b lvl=%0d want 1/8", overflow, level); end
    for (int k = 7; k >= 0; k--) begin
      cyc(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (out !== exp_stack[k] || level !== 4'(k)) begin n_bad++; $display("FAIL unwind%0d: got out=%h lvl=%0d want %h/%0d", k, out, level, exp_stack[k], k); end
    end
    n_cmp++; if (overflow !== 1'b1 || underflow !== 1'b0) begin n_bad++; $display("FAIL ovf_sticky: got %b%b want 10", overflow, underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(16'h0042, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (out !== (TRAP ? 16'h0008 : 16'h0042)) begin n_bad++; $display("FAIL unf_out: got %h want %h", out, TRAP ? 16'h0008 : 16'h0042); end
    n_cmp++; if (underflow !== 1'b1 || level !== 4'd0) begin n_bad++; $display("FAIL unf_flag: got unf=%b lvl=%0d want 1/0", underflow, level); end
    cyc(16'h0500, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (underflow !== 1'b1 || level !== 4'd1 || out !== 16'h0500) begin n_bad++; $display("FAIL unf_sticky: got unf=%b lvl=%0d out=%h want 1/1/0500", underflow, level, out); end
    do_reset();
    n_cmp++; if (underflow !== 1'b0 || level !== 4'd0) begin n_bad++; $display("FAIL unf_clear: got unf=%b lvl=%0d want 0/0", underflow, level); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cyc(16'h0123, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(16'h0400, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(16'h0AAA, 1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (out !== 16'h0AAA || level !== 4'd1) begin n_bad++; $display("FAIL all_strobes: got out=%h lvl=%0d want 0aaa/1", out, level); end
    cyc(16'h0BBB, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (out !== 16'h0BBB || level !== 4'd2) begin n_bad++; $display("FAIL call_ret: got out=%h lvl=%0d want 0bbb/2", out, level); end
    cyc(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (out !== 16'h0AAB || level !== 4'd1) begin n_bad++; $display("FAIL ret_inc: got out=%h lvl=%0d want 0aab/1", out, level); end
    cyc(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (out !== 16'h0124 || level !== 4'd0) begin n_bad++; $display("FAIL ret_last: got out=%h lvl=%0d want 0124/0", out, level); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(16'h0050, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(16'h0700, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (out !== 16'h0051 || empty !== 1'b1) begin n_bad++; $display("FAIL b2b: got out=%h e=%b want 0051/1", out, empty); end
    reset = 1'b0;
    cyc(16'h0900, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    n_cmp++; if (out !== 16'h0000 || level !== 4'd0) begin n_bad++; $display("FAIL reset_call: got out=%h lvl=%0d want 0000/0", out, level); end
  endtask

  initial begin
    reset = 1'b0; in = '0; inc = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
    #2;
    test_reset();
    test_inc_wrap();
    test_call_ret();
    test_nested();
    test_underflow();
    test_simultaneous();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
